inst_fetch_unit: RTL and testbench

//  Upstream stage of the processing socket. Fetches instruction words from instruction memory,

---
 rtl/inst_fetch_unit_pkg.sv | 13 +
 rtl/inst_fetch_unit_fifo.sv | 54 +++++
 rtl/inst_fetch_unit.sv | 133 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: HALT opcode, opcode field width and FSM states.
package inst_fetch_unit_pkg;

    localparam logic [3:0] OPC_HALT  = 4'hF;
    localparam int         OPC_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; the head entry is visible the cycle after it is written.
module inst_fetch_unit_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_q != (AW+1)'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    // Flush dominates: anything pushed or popped in the flush cycle is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: credit-limited reads from instruction memory into a small queue feeding the decoder.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_pc,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    output logic                  busy,
    output logic                  halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = INST_WIDTH + ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] inflight_pc_q;
    logic                  halted_q, halted_d;

    logic                  fetch;
    logic                  push;
    logic                  flush;
    logic                  pop;
    logic                  fifo_valid;
    logic [EW-1:0]         head;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           used;
    logic                  credit_ok;
    logic                  ret_halt;

    // Queued entries plus the response returning this cycle must leave a free slot.
    assign used      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign credit_ok = used < (CW+1)'(FIFO_DEPTH);
    assign ret_halt  = inflight_q && (imem_rdata[INST_WIDTH-1 -: OPC_WIDTH] == OPC_HALT);
    assign pop       = fifo_valid && inst_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fetch    = 1'b0;
        push     = 1'b0;
        flush    = 1'b0;
        halted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = start_pc;
                end
            end
            ST_FETCH: begin
                if (jump_valid) begin
                    flush = 1'b1;
                    pc_d  = jump_pc;
                end else if (ret_halt) begin
                    state_d = ST_DRAIN;
                end else begin
                    push = inflight_q;
                    if (credit_ok) begin
                        fetch = 1'b1;
                        pc_d  = pc_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (jump_valid) begin
                    flush   = 1'b1;
                    pc_d    = jump_pc;
                    state_d = ST_FETCH;
                end else if (!fifo_valid) begin
                    state_d  = ST_IDLE;
                    halted_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= fetch;
            halted_q   <= halted_d;
            if (fetch) inflight_pc_q <= pc_q;
        end
    end

    inst_fetch_unit_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data ({imem_rdata, inflight_pc_q}),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign imem_en    = fetch;
    assign imem_addr  = pc_q;
    assign inst_valid = fifo_valid;
    assign inst_data  = fifo_valid ? head[EW-1 -: INST_WIDTH] : '0;
    assign inst_pc    = fifo_valid ? head[ADDR_WIDTH-1:0] : '0;
    assign busy       = (state_q != ST_IDLE);
    assign halted     = halted_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 1-cycle-latency instruction memory model.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  start_pc;
    logic        jump_valid;
    logic [9:0]  jump_pc;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [9:0]  inst_pc;
    logic        inst_ready;
    logic        busy;
    logic        halted;

    int checks = 0;
    int passed = 0;

    logic [31:0] mem [1024];
    logic [9:0]  exp_fetch;
    logic [9:0]  exp_pop;

    inst_fetch_unit #(
        .INST_WIDTH (32),
        .ADDR_WIDTH (10),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_pc   (start_pc),
        .jump_valid (jump_valid),
        .jump_pc    (jump_pc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_pc = '0; jump_valid = 1'b0; jump_pc = '0; inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({imem_en, imem_addr, inst_valid, inst_data, inst_pc, busy, halted} !== '0)
            $display("FAIL reset_outputs: got en=%b addr=%h v=%b d=%h pc=%h busy=%b halted=%b, want all 0",
                     imem_en, imem_addr, inst_valid, inst_data, inst_pc, busy, halted);
        else passed++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        start = 1'b1; start_pc = 10'h010; inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b0) $display("FAIL idle_no_fetch: got en=%b want 0", imem_en);
        else passed++;
        tick();
        start = 1'b0;
        exp_fetch = 10'h010;
        exp_pop   = 10'h010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({imem_en, imem_addr} !== {1'b1, exp_fetch})
                $display("FAIL stream_fetch: got en=%b addr=%h want en=1 addr=%h", imem_en, imem_addr, exp_fetch);
            else passed++;
            exp_fetch++;
            checks++;
            if (k < 2) begin
                if (inst_valid !== 1'b0) $display("FAIL stream_latency: got valid=%b want 0 at k=%0d", inst_valid, k);
                else passed++;
            end else begin
                if ({inst_valid, inst_pc, inst_data} !== {1'b1, exp_pop, mem[exp_pop]})
                    $display("FAIL stream_pop: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                             inst_valid, inst_pc, inst_data, exp_pop, mem[exp_pop]);
                else passed++;
                exp_pop++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int resumed;
        inst_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if ({inst_valid, inst_pc, inst_data} !== {1'b1, exp_pop, mem[exp_pop]})
                $display("FAIL stall_head: got v=%b pc=%h d=%h want v=1 pc=%h", inst_valid, inst_pc, inst_data, exp_pop);
            else passed++;
            if (imem_en) begin
                checks++;
                if (imem_addr !== exp_fetch) $display("FAIL stall_fetch: got addr=%h want %h", imem_addr, exp_fetch);
                else passed++;
                exp_fetch++;
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b0) $display("FAIL stall_fetch_stops: got en=%b want 0", imem_en);
        else passed++;
        checks++;
        if (exp_fetch - exp_pop !== 10'd4) $display("FAIL stall_queued: got %0d want 4", exp_fetch - exp_pop);
        else passed++;
        tick();
        inst_ready = 1'b1;
        resumed = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({inst_valid, inst_pc, inst_data} !== {1'b1, exp_pop, mem[exp_pop]})
                $display("FAIL resume_pop: got v=%b pc=%h d=%h want v=1 pc=%h", inst_valid, inst_pc, inst_data, exp_pop);
            else passed++;
            exp_pop++;
            if (imem_en) begin
                checks++;
                if (imem_addr !== exp_fetch) $display("FAIL resume_fetch: got addr=%h want %h", imem_addr, exp_fetch);
                else passed++;
                exp_fetch++;
                resumed++;
            end
            tick();
        end
        checks++;
        if (resumed !== 7) $display("FAIL resume_fetch_count: got %0d want 7", resumed);
        else passed++;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_en, imem_addr, inst_valid, inst_data, inst_pc, busy, halted} !== '0)
            $display("FAIL async_reset: got en=%b addr=%h v=%b d=%h pc=%h busy=%b, want all 0",
                     imem_en, imem_addr, inst_valid, inst_data, inst_pc, busy);
        else passed++;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({inst_valid, imem_en, busy} !== 3'b000)
                $display("FAIL stale_after_reset: got v=%b en=%b busy=%b want 000", inst_valid, imem_en, busy);
            else passed++;
            tick();
        end
    endtask

    task automatic test_halt();
        int pops;
        int halts;
        mem[10'h013] = 32'hF000_0000;
        start = 1'b1; start_pc = 10'h010; inst_ready = 1'b1;
        tick();
        start = 1'b0;
        exp_fetch = 10'h010;
        exp_pop   = 10'h010;
        pops  = 0;
        halts = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (imem_en) begin
                checks++;
                if (imem_addr !== exp_fetch || exp_fetch > 10'h013)
                    $display("FAIL halt_fetch: got addr=%h want %h (no fetch past 013)", imem_addr, exp_fetch);
                else passed++;
                exp_fetch++;
            end
            if (inst_valid) begin
                checks++;
                if ({inst_pc, inst_data} !== {exp_pop, mem[exp_pop]} || inst_data[31:28] === 4'hF)
                    $display("FAIL halt_pop: got pc=%h d=%h want pc=%h d=%h (never HALT)", inst_pc, inst_data, exp_pop, mem[exp_pop]);
                else passed++;
                exp_pop++;
                pops++;
            end
            if (halted) begin
                halts++;
                checks++;
                if ({busy, pops} !== {1'b0, 32'd3})
                    $display("FAIL halt_pulse: got busy=%b pops=%0d want busy=0 pops=3", busy, pops);
                else passed++;
            end
            tick();
        end
        checks++;
        if (halts !== 1) $display("FAIL halt_count: got %0d want 1", halts);
        else passed++;
        checks++;
        if (exp_fetch !== 10'h014) $display("FAIL halt_last_fetch: got next=%h want 014", exp_fetch);
        else passed++;
        mem[10'h013] = 32'h0000_0013;
        jump_valid = 1'b1; jump_pc = 10'h100;
        tick();
        jump_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, imem_en} !== 2'b00) $display("FAIL idle_jump_ignored: got busy=%b en=%b want 00", busy, imem_en);
        else passed++;
        tick();
    endtask

    task automatic test_jump();
        start = 1'b1; start_pc = 10'h040; inst_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({imem_en, imem_addr, inst_valid} !== {1'b1, 10'h040 + 10'(k), (k >= 2)})
                $display("FAIL jump_prefill: got en=%b addr=%h v=%b at k=%0d", imem_en, imem_addr, inst_valid, k);
            else passed++;
            tick();
        end
        jump_valid = 1'b1; jump_pc = 10'h200; inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_en, inst_valid, inst_pc} !== {1'b0, 1'b1, 10'h040})
            $display("FAIL jump_cycle: got en=%b v=%b pc=%h want en=0 v=1 pc=040", imem_en, inst_valid, inst_pc);
        else passed++;
        tick();
        jump_valid = 1'b0;
        exp_fetch = 10'h200;
        exp_pop   = 10'h200;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({imem_en, imem_addr} !== {1'b1, exp_fetch})
                $display("FAIL jump_fetch: got en=%b addr=%h want %h", imem_en, imem_addr, exp_fetch);
            else passed++;
            exp_fetch++;
            checks++;
            if (k < 2) begin
                if (inst_valid !== 1'b0) $display("FAIL jump_discard: got v=%b pc=%h want v=0", inst_valid, inst_pc);
                else passed++;
            end else begin
                if ({inst_valid, inst_pc, inst_data} !== {1'b1, exp_pop, mem[exp_pop]})
                    $display("FAIL jump_pop: got v=%b pc=%h d=%h want pc=%h", inst_valid, inst_pc, inst_data, exp_pop);
                else passed++;
                exp_pop++;
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        jump_valid = 1'b1; jump_pc = 10'h3FE;
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b0) $display("FAIL wrap_jump_cycle: got en=%b want 0", imem_en);
        else passed++;
        tick();
        jump_valid = 1'b0;
        exp_fetch = 10'h3FE;
        exp_pop   = 10'h3FE;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({imem_en, imem_addr} !== {1'b1, exp_fetch})
                $display("FAIL wrap_fetch: got en=%b addr=%h want %h", imem_en, imem_addr, exp_fetch);
            else passed++;
            exp_fetch++;
            if (k >= 2) begin
                checks++;
                if ({inst_valid, inst_pc, inst_data} !== {1'b1, exp_pop, mem[exp_pop]})
                    $display("FAIL wrap_pop: got v=%b pc=%h d=%h want pc=%h", inst_valid, inst_pc, inst_data, exp_pop);
                else passed++;
                exp_pop++;
            end
            tick();
            // A start while busy must not disturb the running stream.
            start = (k == 2);
            start_pc = 10'h155;
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        test_reset();
        test_stream();
        test_stall();
        test_reset_mid();
        test_halt();
        test_jump();
        test_wrap();
        rst = 1'b1;
        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
